// File: rtl/mem_arbiter.sv
// Purpose: single-port memory arbiter that sequences an instruction fetch and an optional data access per instruction.
// Latency: 3 cycles per instruction with no data access, 4 with one, plus one cycle for each cycle mem_ack is late.
// Backpressure: strobes are held until mem_ack; cpu_stall stays high except in the one DONE cycle of each instruction.
//
// Ports:
//   clk_in, arb_reset         clock; synchronous active-low reset
//   cpu_pc / cpu_instr        fetch address in, latched instruction word out
//   cpu_daddr, cpu_wdata,
//   cpu_drd, cpu_dwr          data access request (read and write together means write only)
//   cpu_rdata, cpu_stall      latched load data, CPU hold
//   mem_addr, mem_wdata,
//   mem_rd, mem_wr            memory request, held until mem_ack
//   mem_rdata, mem_ack        memory response
//   bus_err, wait_cnt         sticky timeout flag, saturating stall-cycle count
// Option: define ARB_TIMEOUT_EN to enable the TIMEOUT watchdog and the ERR state.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk_in,
   input  logic        arb_reset,
   input  logic [31:0] cpu_pc,
   output logic [31:0] cpu_instr,
   input  logic [31:0] cpu_daddr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_drd,
   input  logic        cpu_dwr,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        bus_err,
   output logic [15:0] wait_cnt
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      DATA   = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } state_t;

   state_t state;

`ifdef ARB_TIMEOUT_EN
   localparam logic [8:0] TO_LIM = 9'(TIMEOUT);
   logic [7:0] to_cnt;
   logic       to_hit;
   // The current cycle is the TIMEOUT-th unacknowledged one: give up at this edge.
   assign to_hit = ({1'b0, to_cnt} + 9'd1) >= TO_LIM;
`endif

   always_ff @(posedge clk_in) begin
      if (!arb_reset) begin
         state     <= IDLE;
         cpu_instr <= '0;
         cpu_rdata <= '0;
         cpu_stall <= 1'b1;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         bus_err   <= 1'b0;
         wait_cnt  <= '0;
`ifdef ARB_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         // Strobes are registered, so this counts exactly the visible wait cycles.
         if ((mem_rd || mem_wr) && !mem_ack && (wait_cnt != 16'hFFFF))
            wait_cnt <= wait_cnt + 16'd1;

         case (state)
            IDLE: begin
               state    <= FETCH;
               mem_rd   <= 1'b1;
               mem_addr <= cpu_pc;
`ifdef ARB_TIMEOUT_EN
               to_cnt   <= '0;
`endif
            end

            FETCH: begin
               if (mem_ack) begin
                  cpu_instr <= mem_rdata;
                  mem_rd    <= 1'b0;
                  state     <= DECODE;
               end
`ifdef ARB_TIMEOUT_EN
               else if (to_hit) begin
                  mem_rd  <= 1'b0;
                  bus_err <= 1'b1;
                  state   <= ERR;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
`endif
            end

            DECODE: begin
               if (cpu_drd || cpu_dwr) begin
                  state     <= DATA;
                  mem_addr  <= cpu_daddr;
                  mem_wdata <= cpu_wdata;
                  mem_wr    <= cpu_dwr;
                  // A simultaneous read and write is carried out as a plain write.
                  mem_rd    <= cpu_drd & ~cpu_dwr;
`ifdef ARB_TIMEOUT_EN
                  to_cnt    <= '0;
`endif
               end else begin
                  state     <= DONE;
                  cpu_stall <= 1'b0;
               end
            end

            DATA: begin
               if (mem_ack) begin
                  if (mem_rd)
                     cpu_rdata <= mem_rdata;
                  mem_rd    <= 1'b0;
                  mem_wr    <= 1'b0;
                  cpu_stall <= 1'b0;
                  state     <= DONE;
               end
`ifdef ARB_TIMEOUT_EN
               else if (to_hit) begin
                  mem_rd  <= 1'b0;
                  mem_wr  <= 1'b0;
                  bus_err <= 1'b1;
                  state   <= ERR;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
`endif
            end

            DONE: begin
               state     <= FETCH;
               cpu_stall <= 1'b1;
               mem_rd    <= 1'b1;
               mem_addr  <= cpu_pc;
`ifdef ARB_TIMEOUT_EN
               to_cnt    <= '0;
`endif
            end

            ERR: begin
               // Absorbing until reset; outputs already parked by the entering edge.
               state <= ERR;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter: directed table, hand-written corner sequences, random instructions vs a transaction model.
// Latency: instruction period and wait counts are predicted per instruction from the memory latencies the bench chooses.
// Backpressure: the bench plays the memory, acknowledging each held request after a chosen number of wait cycles.
module tb_mem_arbiter;

   logic        clk_in;
   logic        arb_reset;
   logic [31:0] cpu_pc;
   logic [31:0] cpu_instr;
   logic [31:0] cpu_daddr;
   logic [31:0] cpu_wdata;
   logic        cpu_drd;
   logic        cpu_dwr;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        bus_err;
   logic [15:0] wait_cnt;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.TIMEOUT(4)) dut (
      .clk_in    (clk_in),
      .arb_reset (arb_reset),
      .cpu_pc    (cpu_pc),
      .cpu_instr (cpu_instr),
      .cpu_daddr (cpu_daddr),
      .cpu_wdata (cpu_wdata),
      .cpu_drd   (cpu_drd),
      .cpu_dwr   (cpu_dwr),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .bus_err   (bus_err),
      .wait_cnt  (wait_cnt)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [31:0] pc;
      logic        drd;
      logic        dwr;
      logic [31:0] daddr;
      logic [31:0] wdata;
      logic [31:0] iword;
      logic [31:0] dword;
      int          flat;
      int          dlat;
      int          e_period;
      int          e_nreq;
      logic        e_rd;
      logic        e_wr;
      logic [31:0] e_rdata;
      logic [15:0] e_wait;
   } vec_t;

   vec_t tv [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   // Starts at a negedge in IDLE or DONE; plays memory until the next DONE cycle.
   task automatic do_instr(input logic [31:0] pc, input logic drd, input logic dwr,
                           input logic [31:0] daddr, input logic [31:0] wdata,
                           input logic [31:0] iword, input logic [31:0] dword,
                           input int flat, input int dlat,
                           output int period, output int nreq,
                           output logic [31:0] f_addr, output logic [31:0] d_addr,
                           output logic [31:0] d_wdata, output logic d_rd, output logic d_wr,
                           output int hold_err);
      int          cnt;
      int          lat;
      logic        active;
      logic [31:0] cur_addr;
      logic        cur_rd;
      logic        cur_wr;
      cpu_pc    = pc;
      cpu_drd   = drd;
      cpu_dwr   = dwr;
      cpu_daddr = daddr;
      cpu_wdata = wdata;
      mem_ack   = 1'b0;
      period = 0; nreq = 0; hold_err = 0; cnt = 0; active = 1'b0;
      f_addr = '0; d_addr = '0; d_wdata = '0; d_rd = 1'b0; d_wr = 1'b0;
      cur_addr = '0; cur_rd = 1'b0; cur_wr = 1'b0;
      for (int c = 0; c < 50; c++) begin
         step();
         period++;
         if (!cpu_stall) break;
         if (mem_rd || mem_wr) begin
            if (!active) begin
               active = 1'b1;
               cnt    = 0;
               nreq++;
               cur_addr = mem_addr; cur_rd = mem_rd; cur_wr = mem_wr;
               if (nreq == 1) f_addr = mem_addr;
               else begin
                  d_addr = mem_addr; d_rd = mem_rd; d_wr = mem_wr; d_wdata = mem_wdata;
               end
            end else if (mem_addr !== cur_addr || mem_rd !== cur_rd || mem_wr !== cur_wr) begin
               hold_err++;
            end
            lat = (nreq == 1) ? flat : dlat;
            if (cnt == lat) begin
               mem_ack   = 1'b1;
               mem_rdata = (nreq == 1) ? iword : (mem_wr ? $urandom : dword);
            end else begin
               mem_ack   = 1'b0;
               mem_rdata = $urandom;
            end
            cnt++;
         end else begin
            // No request outstanding: stray acknowledges must be ignored.
            active    = 1'b0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
         end
      end
      mem_ack = 1'b0;
   endtask

   task automatic apply(input string tag, input logic [31:0] pc, input logic drd, input logic dwr,
                        input logic [31:0] daddr, input logic [31:0] wdata,
                        input logic [31:0] iword, input logic [31:0] dword,
                        input int flat, input int dlat, input int e_period, input int e_nreq,
                        input logic e_rd, input logic e_wr,
                        input logic [31:0] e_rdata, input logic [15:0] e_wait);
      int          period, nreq, hold_err;
      logic [31:0] fa, da, dw;
      logic        drs, dws;
      do_instr(pc, drd, dwr, daddr, wdata, iword, dword, flat, dlat,
               period, nreq, fa, da, dw, drs, dws, hold_err);
      chk({tag, " period"}, period, e_period);
      chk({tag, " nreq"}, nreq, e_nreq);
      chk({tag, " fetch_addr"}, fa, pc);
      chk({tag, " hold"}, hold_err, 0);
      chk({tag, " cpu_instr"}, cpu_instr, iword);
      chk({tag, " cpu_rdata"}, cpu_rdata, e_rdata);
      chk({tag, " wait_cnt"}, {16'b0, wait_cnt}, {16'b0, e_wait});
      if (e_nreq == 2) begin
         chk({tag, " data_addr"}, da, daddr);
         chk({tag, " data_rd"}, {31'b0, drs}, {31'b0, e_rd});
         chk({tag, " data_wr"}, {31'b0, dws}, {31'b0, e_wr});
         if (e_wr) chk({tag, " data_wdata"}, dw, wdata);
      end
   endtask

   initial begin
      logic [31:0] m_rdata;
      int          m_wait;
      int          errs;

      tv[0] = '{32'h0000_0000, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h8C01_0004, 32'h1234_5678,
                0, 0, 4, 2, 1'b1, 1'b0, 32'h1234_5678, 16'd0};
      tv[1] = '{32'h0000_0004, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'h0022_1820, 32'h0,
                3, 0, 6, 1, 1'b0, 1'b0, 32'h1234_5678, 16'd3};
      tv[2] = '{32'h0000_0008, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'hAC03_0100, 32'h0,
                1, 2, 7, 2, 1'b0, 1'b1, 32'h1234_5678, 16'd6};
      tv[3] = '{32'h0000_000C, 1'b1, 1'b1, 32'h0000_0104, 32'h0BAD_F00D, 32'hAC04_0104, 32'h5555_5555,
                0, 1, 5, 2, 1'b0, 1'b1, 32'h1234_5678, 16'd7};
      tv[4] = '{32'h0000_0040, 1'b1, 1'b0, 32'h0000_0108, 32'h0, 32'h8C05_0108, 32'hCAFE_F00D,
                2, 0, 6, 2, 1'b1, 1'b0, 32'hCAFE_F00D, 16'd9};

      // Reset with a stray acknowledge present; it must leave no trace.
      arb_reset = 1'b0;
      cpu_pc = '0; cpu_daddr = '0; cpu_wdata = '0; cpu_drd = 1'b0; cpu_dwr = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      repeat (3) step();
      chk("rst cpu_instr", cpu_instr, 32'h0);
      chk("rst cpu_rdata", cpu_rdata, 32'h0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
      chk("rst wait_cnt", {16'b0, wait_cnt}, 32'h0);
      chk("rst strobes", {30'b0, mem_rd, mem_wr}, 32'h0);
      chk("rst bus_err", {31'b0, bus_err}, 32'h0);
      chk("rst cpu_stall", {31'b0, cpu_stall}, 32'h1);
      mem_ack = 1'b0;
      arb_reset = 1'b1;

      for (int i = 0; i < 5; i++)
         apply($sformatf("v%0d", i), tv[i].pc, tv[i].drd, tv[i].dwr, tv[i].daddr, tv[i].wdata,
               tv[i].iword, tv[i].dword, tv[i].flat, tv[i].dlat, tv[i].e_period, tv[i].e_nreq,
               tv[i].e_rd, tv[i].e_wr, tv[i].e_rdata, tv[i].e_wait);

      // Reset asserted during the second wait cycle of a data read.
      cpu_pc = 32'h80; cpu_drd = 1'b1; cpu_dwr = 1'b0; cpu_daddr = 32'h300; mem_ack = 1'b0;
      step();
      chk("mid fetch rd", {31'b0, mem_rd}, 32'h1);
      mem_ack = 1'b1; mem_rdata = 32'h8C06_0300;
      step();
      mem_ack = 1'b0;
      step();
      chk("mid data rd", {31'b0, mem_rd}, 32'h1);
      chk("mid data addr", mem_addr, 32'h300);
      chk("mid cpu_instr", cpu_instr, 32'h8C06_0300);
      step();
      arb_reset = 1'b0;
      step();
      chk("mid rst strobes", {30'b0, mem_rd, mem_wr}, 32'h0);
      chk("mid rst stall", {31'b0, cpu_stall}, 32'h1);
      chk("mid rst instr", cpu_instr, 32'h0);
      chk("mid rst rdata", cpu_rdata, 32'h0);
      chk("mid rst addr", mem_addr, 32'h0);
      chk("mid rst wait", {16'b0, wait_cnt}, 32'h0);
      arb_reset = 1'b1;

      // Random instructions against a transaction-level model.
      m_rdata = '0;
      m_wait  = 0;
      for (int i = 0; i < 30; i++) begin
         logic [31:0] pc, daddr, wdata, iword, dword;
         logic        drd, dwr, has, rd;
         int          flat, dlat, e_period;
         pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         daddr = $urandom; wdata = $urandom; iword = $urandom; dword = $urandom;
         drd   = 1'($urandom_range(0, 1));
         dwr   = 1'($urandom_range(0, 1));
         flat  = $urandom_range(0, 3);
         dlat  = $urandom_range(0, 3);
         has   = drd | dwr;
         rd    = drd & ~dwr;
         e_period = (flat + 1) + 1 + (has ? dlat + 1 : 0) + 1;
         if (rd) m_rdata = dword;
         m_wait = m_wait + flat + (has ? dlat : 0);
         if (m_wait > 65535) m_wait = 65535;
         apply($sformatf("r%0d", i), pc, drd, dwr, daddr, wdata, iword, dword, flat, dlat,
               e_period, has ? 2 : 1, rd, dwr, m_rdata, 16'(m_wait));
      end

      // Memory that never acknowledges.
      cpu_pc = 32'hC0; cpu_drd = 1'b0; cpu_dwr = 1'b0; mem_ack = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("noack w%0d rd", k), {31'b0, mem_rd}, 32'h1);
         chk($sformatf("noack w%0d err", k), {31'b0, bus_err}, 32'h0);
      end
      step();
`ifdef ARB_TIMEOUT_EN
      chk("to err state rd", {31'b0, mem_rd}, 32'h0);
      chk("to bus_err", {31'b0, bus_err}, 32'h1);
      chk("to stall", {31'b0, cpu_stall}, 32'h1);
      errs = 0;
      for (int k = 0; k < 8; k++) begin
         mem_ack = 1'($urandom_range(0, 1));
         step();
         if (bus_err !== 1'b1 || cpu_stall !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0) errs++;
      end
      mem_ack = 1'b0;
      chk("to absorbing", errs, 0);
      arb_reset = 1'b0;
      step();
      chk("to rst bus_err", {31'b0, bus_err}, 32'h0);
      arb_reset = 1'b1;
`else
      errs = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (cpu_stall !== 1'b1 || bus_err !== 1'b0 || mem_rd !== 1'b1) errs++;
      end
      chk("noack persists", errs, 0);
      chk("noack bus_err", {31'b0, bus_err}, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end want end");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum number of cycles a request waits for mem_ack (1..255).
REQ-002 SHALL have port clk_in, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port arb_reset, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port cpu_pc, input, 32, the instruction fetch address.
REQ-005 SHALL have port cpu_instr, output, 32, the latched instruction word.
REQ-006 SHALL have port cpu_daddr, input, 32, the data address.
REQ-007 SHALL have port cpu_wdata, input, 32, the store data.
REQ-008 SHALL have ports cpu_drd and cpu_dwr, input, 1 each, the data read and data write requests.
REQ-009 SHALL have port cpu_rdata, output, 32, the latched load data.
REQ-010 SHALL have port cpu_stall, output, 1; high means the CPU holds its PC and register file.
REQ-011 SHALL have ports mem_addr and mem_wdata, output, 32 each, the single-port memory address and write data.
REQ-012 SHALL have ports mem_rd and mem_wr, output, 1 each, the memory strobes, held until acknowledged.
REQ-013 SHALL have port mem_rdata, input, 32, the memory read data, valid when mem_ack is high.
REQ-014 SHALL have port mem_ack, input, 1, the transfer-complete pulse.
REQ-015 SHALL have port bus_err, output, 1, a sticky error flag.
REQ-016 SHALL have port wait_cnt, output, 16, a saturating count of stall cycles.

Function
REQ-017 SHALL implement the states IDLE, FETCH, DECODE, DATA, DONE and ERR.
REQ-018 SHALL move IDLE->FETCH on the first cycle after reset is released.
REQ-019 FETCH SHALL drive mem_rd=1 and mem_addr=cpu_pc; on mem_ack it SHALL latch mem_rdata into cpu_instr and go to DECODE.
REQ-020 DECODE SHALL last one cycle with both strobes low; it SHALL then go to DATA if cpu_drd|cpu_dwr, otherwise to DONE.
REQ-021 DATA SHALL drive mem_addr=cpu_daddr, mem_rd=cpu_drd, mem_wr=cpu_dwr and mem_wdata=cpu_wdata.
REQ-022 On mem_ack in DATA, the block SHALL latch mem_rdata into cpu_rdata if the access is a read, then go to DONE.
REQ-023 If cpu_drd and cpu_dwr are both high, the access SHALL be treated as a write only (mem_rd=0) and cpu_rdata SHALL be unchanged.
REQ-024 A mem_ack in the first cycle of a request (zero-wait) SHALL complete that request.
REQ-025 A mem_ack outside FETCH or DATA SHALL be ignored.
REQ-026 DONE SHALL last one cycle with cpu_stall=0, then go to FETCH.
REQ-027 cpu_stall SHALL be 1 in every state except DONE.
REQ-028 The minimum instruction period SHALL be 3 cycles without a data access and 4 cycles with one.
REQ-029 wait_cnt SHALL increment in each cycle that mem_rd|mem_wr is high and mem_ack is low, and SHALL saturate at 16'hFFFF.
REQ-030 ERR SHALL be absorbing: strobes low, cpu_stall=1, bus_err=1, exit only by reset.

Reset
REQ-031 On a clock edge with arb_reset=0, the block SHALL go to IDLE regardless of state, including mid-transfer.
REQ-032 On that same reset edge, cpu_instr, cpu_rdata, mem_addr, mem_wdata and wait_cnt SHALL be 0.
REQ-033 On that same reset edge, mem_rd, mem_wr and bus_err SHALL be 0 and cpu_stall SHALL be 1.
REQ-034 A mem_ack arriving in the reset cycle SHALL be discarded.

Configuration
REQ-035 With macro ARB_TIMEOUT_EN defined, an 8-bit timeout counter SHALL clear on entry to FETCH or DATA and increment on each unacknowledged cycle.
REQ-036 With ARB_TIMEOUT_EN defined, when the timeout counter reaches TIMEOUT without mem_ack, the block SHALL go to ERR on the next edge.
REQ-037 Without ARB_TIMEOUT_EN, the block SHALL wait indefinitely for mem_ack, SHALL have no timeout counter, SHALL hold bus_err at 0, and SHALL never enter ERR.

Verification
REQ-038 Bench SHALL cover: reset, cpu_pc=0x00000000, memory returns 0x8C010004 with zero wait, cpu_drd=1 in DECODE, load returns 0x12345678 with zero wait -> cpu_instr=0x8C010004, cpu_rdata=0x12345678, cpu_stall low exactly in cycle 4, wait_cnt=0.
REQ-039 Bench SHALL cover: R-type fetch with mem_ack delayed 3 cycles -> no DATA state, cpu_stall low once after 6 cycles, wait_cnt=3.
REQ-040 Bench SHALL cover: store with cpu_daddr=0x100 and cpu_wdata=0xDEADBEEF -> mem_wr=1 and mem_addr=0x100 held until mem_ack, then cpu_rdata unchanged.
REQ-041 Bench SHALL cover: cpu_drd=cpu_dwr=1 -> mem_wr=1, mem_rd=0.
REQ-042 Bench SHALL cover: arb_reset=0 during the 2nd wait cycle of DATA -> next cycle mem_rd=mem_wr=0, IDLE, all registers 0, then a new fetch starts on release.
REQ-043 Bench SHALL cover: with ARB_TIMEOUT_EN and TIMEOUT=4, mem_ack never asserted -> ERR after 4 wait cycles, bus_err=1 until reset; without the macro, the stall persists and bus_err=0.
